ysyx_25020037_issue_ctrl: RTL and testbench
===========================================

Name: ysyx_25020037_issue_ctrl

Overview:
- Scoreboard-based issue controller between the decode stage and the execute stage.
- Gates the decode→execute valid/ready handshake on:
  - RAW and WAW register hazards,
  - an in-flight instruction limit,
  - serialization of fence.i and CSR/ecall/mret.
- Tracks pending GPR writebacks with per-register counters updated at issue and at writeback.
- Discards wrong-path decode output on a redirect.

Parameters:
- MAX_INFLIGHT, 3: maximum issued-but-not-retired instructions (1..7).
- PEND_W, 2: width of each per-register pending-write counter; saturation value is 2^PEND_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode output valid
- id_ready  out  1  issue controller accepts the decode output
- id_rs1  in  5  source register 1
- id_rs2  in  5  source register 2
- id_rd  in  5  destination register
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_gpr_we  in  1  instruction writes rd
- id_serial  in  1  fence.i, csrrw, csrrs, ecall or mret; must issue alone
- ex_valid  out  1  issue to execute
- ex_ready  in  1  execute can accept
- wb_valid  in  1  one instruction retires this cycle; asserted for every issued instruction, exactly once
- wb_rd  in  5  retiring destination register
- wb_gpr_we  in  1  retiring instruction wrote rd
- redirect  in  1  branch/jump/trap redirect; current decode output is wrong-path
- drained  out  1  in-flight count == 0
- stall_cycles  out  32  count of cycles with id_valid=1, redirect=0 and no issue

Behaviour:

State registers:
- pend[1..31], PEND_W bits each; pend[0] does not exist and always reads 0.
- inflight, 3 bits.
- state ∈ {RUN, DRAIN, SERIAL}.
- stall_cycles.
- All are cleared on rst; state resets to RUN.
- While rst=1: ex_valid=0, id_ready=0.

Hazard terms use registered values only. A same-cycle writeback does not clear a hazard until the next cycle.
- raw = (id_use_rs1 & rs1≠0 & pend[rs1]≠0) | (id_use_rs2 & rs2≠0 & pend[rs2]≠0)
- waw_full = id_gpr_we & rd≠0 & pend[rd]==max
- cap = inflight==MAX_INFLIGHT

can_issue = id_valid & ~redirect & ~raw & ~waw_full & ~cap & ok_state, where ok_state is:
- RUN: ~id_serial
- DRAIN: id_serial & inflight==0
- SERIAL: 0

Handshake outputs (combinational):
- ex_valid = can_issue.
- id_ready = (can_issue & ex_ready) | redirect.
- issue = ex_valid & ex_ready.

Redirect:
- Consumes and drops the decode output.
- No scoreboard update; no stall count.
- state: DRAIN→RUN. SERIAL is held until its writeback.

Transitions:
- RUN→DRAIN: id_valid & id_serial & ~redirect.
- DRAIN→SERIAL: on issue.
- SERIAL→RUN: on wb_valid.
- ex_valid must stay stable while ex_ready=0. can_issue depends only on registers and the held decode inputs, so it is stable.

Updates per cycle:
- inflight += issue − wb_valid. Never underflows: wb_valid with inflight==0 is a protocol violation; hold inflight at 0.
- pend[rd] += (issue & id_gpr_we & rd≠0); pend[wb_rd] −= (wb_valid & wb_gpr_we & wb_rd≠0).
- Same register incremented and decremented in one cycle: net unchanged.
- Decrement of a 0 counter holds at 0.

Other rules:
- drained = (inflight==0), registered value.
- stall_cycles wraps at 2^32.

Test Plan:
- Reset, then back-to-back independent adds (rd=1,2,3) with ex_ready=1 and no wb → 3 issues in 3 cycles; 4th held (cap); wb_valid one cycle → 4th issues the following cycle; stall_cycles=1.
- Issue rd=5 writer, then reader with id_use_rs1=1, rs1=5 → ex_valid=0 until the cycle after wb_valid with wb_rd=5; reader issues then; pend[5] returns to 0.
- rd=0 writer followed by x0 reader → no stall, no pend update.
- fence.i with 2 in-flight → state DRAIN, ex_valid=0 until both retire; issues at inflight==0; next add waits in SERIAL until fence.i wb, then issues.
- Stalled instruction with redirect=1 → id_ready=1, ex_valid=0, pend/inflight unchanged, stall_cycles not incremented; DRAIN with redirect returns to RUN.
- Issue with rd=7 coincident with wb_rd=7 while pend[7]=1 → pend[7] stays 1. rst mid-DRAIN → all counters 0, state RUN, drained=1 next cycle.

Source files
------------

// File: rtl/ysyx_25020037_issue_ctrl.sv
// Scoreboard-based issue controller sitting between decode and execute.
// Holds decode output back on RAW/WAW hazards, on the in-flight limit and
// while a serializing instruction (fence.i, CSR, ecall, mret) is pending.
// Pending GPR writes are tracked with small saturating per-register counters.
module ysyx_25020037_issue_ctrl #(
  parameter int MAX_INFLIGHT = 3,
  parameter int PEND_W       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_gpr_we,
  input  logic        id_serial,
  output logic        ex_valid,
  input  logic        ex_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        wb_gpr_we,
  input  logic        redirect,
  output logic        drained,
  output logic [31:0] stall_cycles
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [2:0]        CAP      = 3'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SERIAL = 2'd2
  } state_e;

  // Slot 0 is kept permanently at zero so x0 never looks pending.
  logic [PEND_W-1:0] pend_q [32];
  logic [PEND_W-1:0] pend_d [32];
  logic [2:0]        inflight_q, inflight_d;
  state_e            state_q, state_d;
  logic [31:0]       stall_q, stall_d;

  logic raw, waw_full, cap, ok_state, can_issue, issue;

  // Saturating counter helpers: a full counter never wraps to zero and an
  // empty counter never wraps to full.
  function automatic logic [PEND_W-1:0] sat_inc(input logic [PEND_W-1:0] v);
    return (v == PEND_MAX) ? v : v + PEND_ONE;
  endfunction

  function automatic logic [PEND_W-1:0] sat_dec(input logic [PEND_W-1:0] v);
    return (v == '0) ? v : v - PEND_ONE;
  endfunction

  // Hazard and issue qualification from registered scoreboard state only.
  always_comb begin
    raw      = (id_use_rs1 && (id_rs1 != 5'd0) && (pend_q[id_rs1] != '0)) ||
               (id_use_rs2 && (id_rs2 != 5'd0) && (pend_q[id_rs2] != '0));
    waw_full = id_gpr_we && (id_rd != 5'd0) && (pend_q[id_rd] == PEND_MAX);
    cap      = (inflight_q == CAP);
    ok_state = 1'b0;
    unique case (state_q)
      RUN:     ok_state = !id_serial;
      DRAIN:   ok_state = id_serial && (inflight_q == 3'd0);
      SERIAL:  ok_state = 1'b0;
      default: ok_state = 1'b0;
    endcase
    can_issue = id_valid && !redirect && !raw && !waw_full && !cap && ok_state;
  end

  // Handshake is forced idle while reset is held.
  assign ex_valid     = can_issue && !rst;
  assign id_ready     = ((can_issue && ex_ready) || redirect) && !rst;
  assign issue        = ex_valid && ex_ready;
  assign drained      = (inflight_q == 3'd0);
  assign stall_cycles = stall_q;

  // Serialization state: wait for the pipe to empty, issue alone, then wait
  // for the serializing instruction to retire.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (id_valid && id_serial && !redirect) state_d = DRAIN;
      DRAIN: begin
        if (redirect)   state_d = RUN;
        else if (issue) state_d = SERIAL;
      end
      SERIAL:  if (wb_valid) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Per-register pending-write counters: +1 at issue, -1 at writeback.
  always_comb begin
    pend_d    = pend_q;
    pend_d[0] = '0;
    for (int i = 1; i < 32; i++) begin
      if ((issue && id_gpr_we && (id_rd == 5'(i))) &&
          !(wb_valid && wb_gpr_we && (wb_rd == 5'(i))))
        pend_d[i] = sat_inc(pend_q[i]);
      else if ((wb_valid && wb_gpr_we && (wb_rd == 5'(i))) &&
               !(issue && id_gpr_we && (id_rd == 5'(i))))
        pend_d[i] = sat_dec(pend_q[i]);
    end
  end

  // In-flight count; a stray writeback with nothing in flight is ignored.
  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue, wb_valid})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   if (inflight_q != 3'd0) inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Stall counter: a valid, non-redirected decode output that did not issue.
  always_comb begin
    stall_d = stall_q;
    if (id_valid && !redirect && !issue) stall_d = stall_q + 32'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      inflight_q <= 3'd0;
      stall_q    <= 32'd0;
      for (int i = 0; i < 32; i++) pend_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      stall_q    <= stall_d;
      for (int i = 0; i < 32; i++) pend_q[i] <= pend_d[i];
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_issue_ctrl.sv
// Directed bench for the issue controller. A list-of-in-flight-instructions
// model predicts the handshake, drained and stall count every cycle; literal
// checks pin the key points of each scenario.
module tb_ysyx_25020037_issue_ctrl;

  localparam int MAXI  = 3;
  localparam int PW    = 2;
  localparam int PMAX  = (1 << PW) - 1;

  logic        clk;
  logic        rst;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_gpr_we, id_serial;
  logic        ex_valid, ex_ready;
  logic        wb_valid, wb_gpr_we;
  logic [4:0]  wb_rd;
  logic        redirect;
  logic        drained;
  logic [31:0] stall_cycles;

  int vecs = 0;
  int miss = 0;
  bit armed = 0;

  ysyx_25020037_issue_ctrl #(.MAX_INFLIGHT(MAXI), .PEND_W(PW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_gpr_we(id_gpr_we), .id_serial(id_serial),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_gpr_we(wb_gpr_we),
    .redirect(redirect), .drained(drained), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed { logic [4:0] rd; logic w; } ent_t;
  ent_t        fl[$];
  bit          m_draining, m_serial_busy;
  int unsigned m_stall;

  function automatic int m_pend(input logic [4:0] r);
    int n = 0;
    if (r == 5'd0) return 0;
    foreach (fl[k]) if (fl[k].w && fl[k].rd == r) n++;
    return n;
  endfunction

  function automatic bit m_can();
    bit ok;
    if (!id_valid || redirect) return 0;
    if (id_use_rs1 && m_pend(id_rs1) != 0) return 0;
    if (id_use_rs2 && m_pend(id_rs2) != 0) return 0;
    if (id_gpr_we && m_pend(id_rd) >= PMAX) return 0;
    if (fl.size() >= MAXI) return 0;
    if (m_serial_busy)   ok = 0;
    else if (m_draining) ok = id_serial && (fl.size() == 0);
    else                 ok = !id_serial;
    return ok;
  endfunction

  always @(negedge clk) begin
    bit   exv, iss, eff;
    int   idx;
    ent_t e;
    if (armed) begin
      exv = !rst && m_can();
      chk("ex_valid", ex_valid, exv);
      chk("id_ready", id_ready, !rst && ((exv && ex_ready) || redirect));
      chk("drained", drained, fl.size() == 0);
      chk("stall_cycles", stall_cycles, m_stall);
      if (rst) begin
        fl.delete();
        m_draining = 0;
        m_serial_busy = 0;
        m_stall = 0;
      end else begin
        iss = exv && ex_ready;
        if (id_valid && !redirect && !iss) m_stall++;
        if (m_serial_busy) begin
          if (wb_valid) m_serial_busy = 0;
        end else if (m_draining) begin
          if (redirect) m_draining = 0;
          else if (iss) begin m_draining = 0; m_serial_busy = 1; end
        end else if (id_valid && id_serial && !redirect) m_draining = 1;
        if (wb_valid && fl.size() > 0) begin
          eff = wb_gpr_we && (wb_rd != 5'd0);
          idx = -1;
          foreach (fl[k])
            if (idx < 0 && (eff ? (fl[k].w && fl[k].rd == wb_rd) : !fl[k].w)) idx = k;
          if (idx < 0) idx = 0;
          fl.delete(idx);
        end
        if (iss) begin
          e.rd = id_rd;
          e.w  = id_gpr_we && (id_rd != 5'd0);
          fl.push_back(e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [4:0] rd);
    id_valid = 1; id_rd = rd; id_gpr_we = 1; id_serial = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
  endtask

  task automatic rdr(input logic [4:0] rs);
    id_valid = 1; id_rd = 0; id_gpr_we = 0; id_serial = 0;
    id_use_rs1 = 1; id_use_rs2 = 0; id_rs1 = rs; id_rs2 = 0;
  endtask

  task automatic ser();
    id_valid = 1; id_rd = 0; id_gpr_we = 0; id_serial = 1;
    id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
  endtask

  task automatic wbk(input logic [4:0] rd, input logic we);
    wb_valid = 1; wb_rd = rd; wb_gpr_we = we;
  endtask

  initial begin
    rst = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_gpr_we = 0; id_serial = 0;
    ex_ready = 1; wb_valid = 0; wb_rd = 0; wb_gpr_we = 0; redirect = 0;
    @(posedge clk); #1; armed = 1;
    cyc(1); rst = 0; #1;
    chk("reset_drained", drained, 1);
    chk("reset_stall", stall_cycles, 0);
    chk("reset_exv", ex_valid, 0);

    // back-to-back independent writers, then the in-flight cap
    wr(1); #1 chk("t1_first_issue", ex_valid, 1);
    cyc(1); wr(2); cyc(1); wr(3); cyc(1);
    wr(4); wbk(1, 1); #1 chk("t1_cap_hold", ex_valid, 0);
    cyc(1); wb_valid = 0; #1 chk("t1_4th_issues", ex_valid, 1);
    cyc(1); id_valid = 0; #1 chk("t1_stall_count", stall_cycles, 1);
    wbk(2, 1); cyc(1); wbk(3, 1); cyc(1); wbk(4, 1); cyc(1);
    wb_valid = 0; #1 chk("t1_drained", drained, 1);

    // RAW on x5, released the cycle after its writeback
    wr(5); cyc(1);
    rdr(5); #1 chk("t2_raw_hold", ex_valid, 0);
    cyc(2); wbk(5, 1); #1 chk("t2_same_cycle_wb", ex_valid, 0);
    cyc(1); wb_valid = 0; #1 chk("t2_after_wb", ex_valid, 1);
    cyc(1); id_valid = 0; wbk(0, 0); cyc(1); wb_valid = 0;
    rdr(5); #1 chk("t2_pend5_clear", ex_valid, 1);
    cyc(1); id_valid = 0; wbk(0, 0); cyc(1); wb_valid = 0;

    // x0 writer and x0 reader never interlock
    wr(0); #1 chk("t3_x0_writer", ex_valid, 1);
    cyc(1); rdr(0); #1 chk("t3_x0_reader", ex_valid, 1);
    cyc(1); id_valid = 0; wbk(0, 1); cyc(1); wbk(0, 0); cyc(1); wb_valid = 0;

    // fence.i drains two in-flight, issues alone, then blocks the next add
    wr(8); cyc(1); wr(9); cyc(1);
    ser(); #1 chk("t4_fence_run", ex_valid, 0);
    cyc(1); #1 chk("t4_fence_drain", ex_valid, 0);
    wbk(8, 1); cyc(1); wbk(9, 1); #1 chk("t4_last_wb", ex_valid, 0);
    cyc(1); wb_valid = 0; #1 chk("t4_fence_issue", ex_valid, 1);
    cyc(1); wr(10); #1 chk("t4_serial_hold", ex_valid, 0);
    cyc(1); wbk(0, 0); #1 chk("t4_serial_wb_cycle", ex_valid, 0);
    cyc(1); wb_valid = 0; #1 chk("t4_after_serial", ex_valid, 1);
    cyc(1); id_valid = 0; wbk(10, 1); cyc(1); wb_valid = 0;

    // redirect drops a stalled instruction and pulls DRAIN back to RUN
    wr(11); cyc(1);
    rdr(11); #1 chk("t5_stalled", ex_valid, 0);
    cyc(1); redirect = 1; #1 chk("t5_redir_ready", id_ready, 1);
    chk("t5_redir_exv", ex_valid, 0);
    cyc(1); redirect = 0; ser(); cyc(1);
    redirect = 1; cyc(1);
    redirect = 0; wr(12); #1 chk("t5_back_to_run", ex_valid, 1);
    cyc(1); id_valid = 0; wbk(11, 1); cyc(1); wbk(12, 1); cyc(1); wb_valid = 0;

    // issue to x7 coincident with x7 writeback keeps one write pending
    wr(7); cyc(1);
    wr(7); wbk(7, 1); #1 chk("t6_coincident_issue", ex_valid, 1);
    cyc(1); wb_valid = 0; rdr(7); #1 chk("t6_pend7_still_set", ex_valid, 0);
    cyc(1); wbk(7, 1); cyc(1); wb_valid = 0; #1 chk("t6_pend7_clear", ex_valid, 1);
    cyc(1); id_valid = 0; wbk(0, 0); cyc(1); wb_valid = 0;

    // stray writeback with nothing in flight
    wbk(3, 1); cyc(1); wb_valid = 0; #1 chk("t6_no_underflow", drained, 1);

    // reset in the middle of a drain
    wr(14); cyc(1); ser(); cyc(1);
    rst = 1; #1 chk("t7_rst_exv", ex_valid, 0);
    chk("t7_rst_ready", id_ready, 0);
    cyc(1); rst = 0; id_valid = 0; #1 chk("t7_drained", drained, 1);
    chk("t7_stall_zero", stall_cycles, 0);
    wr(15); #1 chk("t7_run_after_rst", ex_valid, 1);
    cyc(1); id_valid = 0; wbk(15, 1); cyc(1); wb_valid = 0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
